// File: rtl/uart_tx_baud.sv
// uart_tx_baud: UART transmitter with built-in baud divider (start/data/parity/stop framing).
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input FIFO for gap-free back-to-back frames.
module uart_tx_baud #(
  parameter int CLK_RATE   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = 4;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_baud
    $error("uart_tx_baud: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
    $error("uart_tx_baud: DATA_WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_tx_baud: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_baud: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_baud: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity is taken from the accepted word, never from the line.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
    if (PARITY == 1) begin
      parity_of = ~^word;
    end else begin
      parity_of = ^word;
    end
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;

  logic                    bit_end_s;
  logic                    stop_end_s;
  logic                    take_s;
  logic [DATA_WIDTH-1:0]   word_s;

  assign bit_end_s  = (cnt_q == CNT_LAST);
  assign stop_end_s = (state_q == ST_STOP) && bit_end_s && (idx_q == STOP_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  push_s;
  logic                  empty_s;

  // FIFO pointers; pop at idle or on the last stop cycle so frames chain with no gap.
  always_comb begin
    push_s   = i_tx_valid && ready_q;
    empty_s  = (wr_ptr_q == rd_ptr_q);
    take_s   = !empty_s && ((state_q == ST_IDLE) || stop_end_s);
    word_s   = mem_q[rd_ptr_q[PTR_W-1:0]];
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = take_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    ready_d  = !((wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                 (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]));
  end

  // FIFO pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {(PTR_W+1){1'b0}};
      rd_ptr_q <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= i_tx_data;
    end
  end
`else
  // Direct handshake: a word is only taken while idle.
  always_comb begin
    take_s  = (state_q == ST_IDLE) && i_tx_valid && ready_q;
    word_s  = i_tx_data;
    ready_d = (state_d == ST_IDLE);
  end
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      shift_q <= {DATA_WIDTH{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next state: the baud counter wraps at each bit end, which is also the only point of state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (take_s) begin
          state_d = ST_START;
          shift_d = word_s;
          par_d   = parity_of(word_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s && (idx_q == STOP_LAST)) begin
          idx_d = {IDX_W{1'b0}};
          if (take_s) begin
            state_d = ST_START;
            shift_d = word_s;
            par_d   = parity_of(word_s);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bit_end_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from next-state values so the registered line lines up with state_q.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_tx_done  = done_q;
  assign o_tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Self-checking bench for uart_tx_baud: three parity/stop configurations, line checked every cycle
// against an expected-waveform queue; the FIFO burst scenario is built when UART_TX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_baud;

  localparam int CPB = 10;
`ifdef UART_TX_FIFO_EN
  localparam logic FIFO_ON = 1'b1;
`else
  localparam logic FIFO_ON = 1'b0;
`endif
  localparam int   LAT_IDLE = FIFO_ON ? 1 : 0;
  localparam logic IDLE_OBS = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic       tx_a, ready_a, busy_a, done_a;
  logic       tx_b, ready_b, busy_b, done_b;
  logic       tx_c, ready_c, busy_c, done_c;

  int tests = 0;
  int failed = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_baud #(.CLK_RATE(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_tx_done(done_a));

  uart_tx_baud #(.CLK_RATE(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
                 .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_tx_done(done_b));

  uart_tx_baud #(.CLK_RATE(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid_c),
    .o_tx_ready(ready_c), .o_tx(tx_c), .o_busy(busy_c), .o_tx_done(done_c));

  // Observation vector {tx, busy, done, ready} of the selected instance.
  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       obs = {tx_a, busy_a, done_a, ready_a};
      1:       obs = {tx_b, busy_b, done_b, ready_b};
      default: obs = {tx_c, busy_c, done_c, ready_c};
    endcase
  endfunction

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       valid_a = v;
      1:       valid_b = v;
      default: valid_c = v;
    endcase
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1});
  endtask

  // Expected per-cycle waveform of one frame, built from the word and the frame format.
  task automatic push_frame(input logic [7:0] w, input int pmode, input int sbits, input logic rdy);
    logic lb [16];
    int nb;
    lb[0] = 1'b0;
    for (int i = 0; i < 8; i++) lb[1+i] = w[i];
    nb = 9;
    if (pmode == 1) begin lb[nb] = ~^w; nb++; end
    else if (pmode == 2) begin lb[nb] = ^w; nb++; end
    for (int s = 0; s < sbits; s++) begin lb[nb] = 1'b1; nb++; end
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < CPB; c++)
        exp_q.push_back({lb[b], 1'b1, (b == nb-1 && c == CPB-1) ? 1'b1 : 1'b0, rdy});
  endtask

  // One-cycle valid pulse; the data bus is scrambled right after acceptance.
  task automatic start_word(input int sel, input logic [7:0] w);
    @(posedge clk); #1;
    data = w;
    set_valid(sel, 1'b1);
    @(posedge clk); #1;
    set_valid(sel, 1'b0);
    data = ~w;
  endtask

  task automatic test_reset;
    logic [3:0] o;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
        o = obs(s);
        tests++;
        if (o !== {1'b1, 1'b0, 1'b0, IDLE_OBS}) begin
          failed++;
          $display("FAIL reset_idle dut=%0d cyc=%0d {tx,busy,done,ready} got=%b exp=1001", s, k, o);
        end
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] words [4];
    logic [3:0] e, o;
    int n;
    words[0] = 8'hA5; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h81;
    for (int w = 0; w < 4; w++) begin
      exp_q.delete();
      push_idle(LAT_IDLE);
      push_frame(words[w], 0, 1, FIFO_ON);
      push_idle(2);
      start_word(0, words[w]);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = obs(0);
        tests++;
        if (o !== e) begin
          failed++;
          $display("FAIL basic word=%h cyc=%0d {tx,busy,done,ready} got=%b exp=%b", words[w], k, o, e);
        end
      end
    end
  endtask

  task automatic test_parity;
    logic [3:0] e, o;
    int n;
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      push_idle(LAT_IDLE);
      if (t == 0) push_frame(8'hA5, 1, 1, FIFO_ON);
      else        push_frame(8'h07, 2, 2, FIFO_ON);
      push_idle(2);
      start_word(t + 1, (t == 0) ? 8'hA5 : 8'h07);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = obs(t + 1);
        tests++;
        if (o !== e) begin
          failed++;
          $display("FAIL parity dut=%0d cyc=%0d {tx,busy,done,ready} got=%b exp=%b", t + 1, k, o, e);
        end
      end
    end
  endtask

  task automatic test_two_stop;
    logic [3:0] e, o;
    int n;
    exp_q.delete();
    push_idle(LAT_IDLE);
    push_frame(8'h3C, 2, 2, FIFO_ON);
    push_idle(3);
    start_word(2, 8'h3C);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(2);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL two_stop cyc=%0d {tx,busy,done,ready} got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_midframe_reset;
    logic [3:0] e, o;
    int n;
    exp_q.delete();
    push_idle(LAT_IDLE);
    push_frame(8'h5A, 0, 1, FIFO_ON);
    start_word(0, 8'h5A);
    for (int k = 0; k < 45 + LAT_IDLE; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(0);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL rst_prefix cyc=%0d {tx,busy,done,ready} got=%b exp=%b", k, o, e);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    push_idle(3);
    push_frame(8'hC3, 0, 1, FIFO_ON);
    push_idle(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(0);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL rst_abort cyc=%0d {tx,busy,done,ready} got=%b exp=%b", k, o, e);
      end
    end
    push_idle(0);
    exp_q.push_front({1'b1, 1'b0, 1'b0, 1'b1});
    exp_q.delete(0);
    for (int i = 0; i < LAT_IDLE; i++) exp_q.push_front({1'b1, 1'b0, 1'b0, 1'b1});
    start_word(0, 8'hC3);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(0);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL rst_next_frame cyc=%0d {tx,busy,done,ready} got=%b exp=%b", k, o, e);
      end
    end
  endtask

`ifndef UART_TX_FIFO_EN
  // Valid held high across two frames: second frame must follow exactly one idle cycle.
  task automatic test_back_to_back;
    logic [3:0] e, o;
    int n;
    exp_q.delete();
    push_frame(8'h3C, 0, 1, 1'b0);
    push_idle(1);
    push_frame(8'hC3, 0, 1, 1'b0);
    push_idle(2);
    @(posedge clk); #1;
    data = 8'h3C;
    valid_a = 1'b1;
    @(posedge clk); #1;
    data = 8'hC3;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(0);
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL back_to_back cyc=%0d {tx,busy,done,ready} got=%b exp=%b", k, o, e);
      end
      if (k == 10 * CPB + 1) valid_a = 1'b0;
    end
  endtask
`else
  // Six words pushed as fast as ready allows; frames must chain with no idle cycle.
  task automatic test_fifo_burst;
    logic [7:0] w [6];
    logic [3:0] e, o;
    int n, acc, first_low, guard;
    logic r;
    w[0] = 8'h11; w[1] = 8'hA5; w[2] = 8'h3C; w[3] = 8'hF0; w[4] = 8'h0F; w[5] = 8'h96;
    exp_q.delete();
    push_idle(2);
    for (int i = 0; i < 6; i++) push_frame(w[i], 0, 1, 1'b1);
    push_idle(2);
    acc = 0;
    first_low = -1;
    guard = 0;
    @(posedge clk); #1;
    data = w[0];
    valid_a = 1'b1;
    fork
      begin
        while (acc < 6 && guard < 2000) begin
          @(negedge clk);
          r = ready_a;
          @(posedge clk); #1;
          if (r) begin
            acc++;
            if (acc < 6) data = w[acc];
            else valid_a = 1'b0;
          end else if (first_low < 0) begin
            first_low = acc;
          end
          guard++;
        end
        valid_a = 1'b0;
      end
      begin
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
          @(negedge clk);
          e = exp_q.pop_front();
          o = obs(0);
          tests++;
          if ((o & 4'b1110) !== (e & 4'b1110)) begin
            failed++;
            $display("FAIL fifo_burst cyc=%0d {tx,busy,done,x} got=%b exp=%b", k, o, e);
          end
        end
      end
    join
    tests++;
    if (acc !== 6) begin
      failed++;
      $display("FAIL fifo_accepted got=%0d exp=6", acc);
    end
    // Four words fill the FIFO while a fifth is already on the line.
    tests++;
    if (first_low !== 5) begin
      failed++;
      $display("FAIL fifo_ready_low_after got=%0d exp=5", first_low);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_midframe_reset();
`ifndef UART_TX_FIFO_EN
    test_back_to_back();
`else
    test_fifo_burst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
